reg_to_axi_lite: RTL and testbench

Bridge from a register-bus initiator to an AXI4-Lite master port, the reverse direction of the existing AXI-Lite-to-register-bus converters. It lets regbus-side agents (debug/boot sequencers, testbench register drivers) reach AXI-Lite peripherals such as the bootrom and FLL configuration ports. It handles one transaction at a time through a small state machine. An optional response watchdog keeps a stalled peripheral from hanging the register bus.

---
 rtl/reg_to_axi_lite.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_reg_to_axi_lite.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_to_axi_lite.sv
// ---------------------------------------------------------------------------
// reg_to_axi_lite
//
// Purpose: bridges a register-bus initiator onto an AXI4-Lite master port.
// A single transaction is in flight at a time. The request is captured in
// IDLE, its address/data phases are issued on AW/W (write) or AR (read),
// and the B/R response is folded back into one regbus response cycle.
//
// Ports:
//   clk_i          - clock
//   rst_ni         - asynchronous active-low reset
//   reg_req_i      - regbus request  (addr, write, wdata, wstrb, valid)
//   reg_rsp_o      - regbus response (rdata, error, ready)
//   axi_lite_req_o - AXI-Lite request  (aw, w, b_ready, ar, r_ready)
//   axi_lite_rsp_i - AXI-Lite response (aw_ready, w_ready, b, ar_ready, r)
//
// Optional feature: define REG_TO_AXI_LITE_TIMEOUT_EN to add a response
// watchdog. After TIMEOUT_CYCLES without B/R the bridge answers with
// error=1 and then drains the late response in a DRAIN state before it
// accepts the next request.
// ---------------------------------------------------------------------------

package reg_to_axi_lite_pkg;

   typedef struct packed {
      logic [47:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   typedef struct packed {
      logic [47:0] addr;
      logic [2:0]  prot;
   } axi_lite_ax_t;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
   } axi_lite_w_t;

   typedef struct packed {
      logic [1:0] resp;
   } axi_lite_b_t;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } axi_lite_r_t;

   typedef struct packed {
      axi_lite_ax_t aw;
      logic         aw_valid;
      axi_lite_w_t  w;
      logic         w_valid;
      logic         b_ready;
      axi_lite_ax_t ar;
      logic         ar_valid;
      logic         r_ready;
   } axi_lite_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      axi_lite_b_t b;
      logic        b_valid;
      logic        ar_ready;
      axi_lite_r_t r;
      logic        r_valid;
   } axi_lite_rsp_t;

endpackage

module reg_to_axi_lite #(
   parameter int unsigned ADDR_WIDTH     = 48,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter type reg_req_t      = reg_to_axi_lite_pkg::reg_req_t,
   parameter type reg_rsp_t      = reg_to_axi_lite_pkg::reg_rsp_t,
   parameter type axi_lite_req_t = reg_to_axi_lite_pkg::axi_lite_req_t,
   parameter type axi_lite_rsp_t = reg_to_axi_lite_pkg::axi_lite_rsp_t
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  reg_req_t      reg_req_i,
   output reg_rsp_t      reg_rsp_o,
   output axi_lite_req_t axi_lite_req_o,
   input  axi_lite_rsp_t axi_lite_rsp_i
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WRITE  = 3'd1;
   localparam logic [2:0] WAIT_B = 3'd2;
   localparam logic [2:0] READ   = 3'd3;
   localparam logic [2:0] WAIT_R = 3'd4;
   localparam logic [2:0] RESP   = 3'd5;
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
   localparam logic [2:0] DRAIN  = 3'd6;
   localparam int unsigned WDOG_WIDTH = $clog2(TIMEOUT_CYCLES);
   localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);
`endif

   // The watchdog must allow at least one real wait cycle before firing.
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("reg_to_axi_lite: TIMEOUT_CYCLES must be at least 2");
   end

   logic [2:0]            state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  write_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  error_q;
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
   logic [WDOG_WIDTH-1:0] wdog_q;
   logic                  timed_out_q;
`endif

   logic aw_hs;
   logic w_hs;
   logic b_hs;
   logic ar_hs;
   logic r_hs;

   // Handshakes are evaluated on the registered outputs, so every valid
   // and ready driven here comes from state/flags only.
   assign aw_hs = axi_lite_req_o.aw_valid && axi_lite_rsp_i.aw_ready;
   assign w_hs  = axi_lite_req_o.w_valid  && axi_lite_rsp_i.w_ready;
   assign b_hs  = axi_lite_req_o.b_ready  && axi_lite_rsp_i.b_valid;
   assign ar_hs = axi_lite_req_o.ar_valid && axi_lite_rsp_i.ar_ready;
   assign r_hs  = axi_lite_req_o.r_ready  && axi_lite_rsp_i.r_valid;

   // Output decode. Valids fall the cycle after their own handshake because
   // the matching done flag is set at that edge. After a watchdog timeout the
   // response ready stays high from RESP through DRAIN so a late beat can be
   // swallowed at any point.
   always_comb begin
      axi_lite_req_o          = '0;
      axi_lite_req_o.aw.addr  = addr_q;
      axi_lite_req_o.aw.prot  = 3'b000;
      axi_lite_req_o.aw_valid = (state_q == WRITE) && !aw_done_q;
      axi_lite_req_o.w.data   = wdata_q;
      axi_lite_req_o.w.strb   = wstrb_q;
      axi_lite_req_o.w_valid  = (state_q == WRITE) && !w_done_q;
      axi_lite_req_o.ar.addr  = addr_q;
      axi_lite_req_o.ar.prot  = 3'b000;
      axi_lite_req_o.ar_valid = (state_q == READ);
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
      axi_lite_req_o.b_ready  = (state_q == WAIT_B) ||
                                (write_q && timed_out_q &&
                                 ((state_q == RESP) || (state_q == DRAIN)));
      axi_lite_req_o.r_ready  = (state_q == WAIT_R) ||
                                (!write_q && timed_out_q &&
                                 ((state_q == RESP) || (state_q == DRAIN)));
`else
      axi_lite_req_o.b_ready  = (state_q == WAIT_B);
      axi_lite_req_o.r_ready  = (state_q == WAIT_R);
`endif

      reg_rsp_o       = '0;
      reg_rsp_o.rdata = rdata_q;
      reg_rsp_o.error = error_q;
      reg_rsp_o.ready = (state_q == RESP);
   end

   // Transaction sequencer. The request payload is captured once in IDLE and
   // never re-sampled, so the AXI payload is stable while any valid is high.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
         wdog_q      <= '0;
         timed_out_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (reg_req_i.valid) begin
                  addr_q      <= reg_req_i.addr;
                  wdata_q     <= reg_req_i.wdata;
                  wstrb_q     <= reg_req_i.wstrb;
                  write_q     <= reg_req_i.write;
                  aw_done_q   <= 1'b0;
                  w_done_q    <= 1'b0;
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
                  timed_out_q <= 1'b0;
`endif
                  state_q     <= reg_req_i.write ? WRITE : READ;
               end
            end

            WRITE: begin
               if (aw_hs) aw_done_q <= 1'b1;
               if (w_hs)  w_done_q  <= 1'b1;
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
                  wdog_q  <= '0;
`endif
                  state_q <= WAIT_B;
               end
            end

            WAIT_B: begin
               if (b_hs) begin
                  error_q <= (axi_lite_rsp_i.b.resp != 2'b00);
                  rdata_q <= '0;
                  state_q <= RESP;
               end
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
               else if (wdog_q == WDOG_LAST) begin
                  error_q     <= 1'b1;
                  rdata_q     <= '0;
                  timed_out_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
`endif
            end

            READ: begin
               if (ar_hs) begin
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
                  wdog_q  <= '0;
`endif
                  state_q <= WAIT_R;
               end
            end

            WAIT_R: begin
               // A read error still returns whatever data the slave sent.
               if (r_hs) begin
                  rdata_q <= axi_lite_rsp_i.r.data;
                  error_q <= (axi_lite_rsp_i.r.resp != 2'b00);
                  state_q <= RESP;
               end
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
               else if (wdog_q == WDOG_LAST) begin
                  error_q     <= 1'b1;
                  rdata_q     <= '0;
                  timed_out_q <= 1'b1;
                  state_q     <= RESP;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
`endif
            end

            RESP: begin
`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
               // If the late beat already landed during RESP there is
               // nothing left to drain.
               if (timed_out_q && !(write_q ? b_hs : r_hs)) begin
                  state_q <= DRAIN;
               end else begin
                  state_q <= IDLE;
               end
`else
               state_q <= IDLE;
`endif
            end

`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
            DRAIN: begin
               if (write_q ? b_hs : r_hs) begin
                  state_q <= IDLE;
               end
            end
`endif

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_to_axi_lite.sv
// ---------------------------------------------------------------------------
// tb_reg_to_axi_lite
//
// Self-checking bench for reg_to_axi_lite. Each transaction is described by
// its slave wait counts; the expected cycle of every AXI handshake and of the
// regbus ready is derived from the bridge's latency rules, and a single
// compare process checks all outputs against those windows every cycle.
// Define REG_TO_AXI_LITE_TIMEOUT_EN to also exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_reg_to_axi_lite;
   import reg_to_axi_lite_pkg::*;

`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
   localparam int TMO   = 16;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TMO   = 1024;
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   reg_req_t      reg_req;
   reg_rsp_t      reg_rsp;
   axi_lite_req_t axi_req;
   axi_lite_rsp_t axi_rsp;

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   reg_to_axi_lite #(
      .ADDR_WIDTH    (48),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .reg_req_i     (reg_req),
      .reg_rsp_o     (reg_rsp),
      .axi_lite_req_o(axi_req),
      .axi_lite_rsp_i(axi_rsp)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cur_rel  = 0;
   bit check_en = 1'b0;

   logic        exp_aw_valid, exp_w_valid, exp_b_ready, exp_ar_valid, exp_r_ready;
   logic        exp_ready, exp_error;
   logic [31:0] exp_rdata, exp_wdata;
   logic [47:0] exp_addr;
   logic [3:0]  exp_wstrb;

   int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, ready_cnt, ready_rel;
   logic        obs_error;
   logic [31:0] obs_rdata;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d of txn)", name, act, req, cur_rel);
      end
   endtask

   task automatic clearExpect();
      exp_aw_valid = 1'b0; exp_w_valid = 1'b0; exp_b_ready = 1'b0;
      exp_ar_valid = 1'b0; exp_r_ready = 1'b0; exp_ready  = 1'b0;
      exp_error    = 1'b0; exp_rdata   = '0;   exp_wdata   = '0;
      exp_addr     = '0;   exp_wstrb   = '0;
   endtask

   // All regbus/AXI outputs must be in their reset values.
   task automatic checkResetOutputs(input string tag);
      check({tag, "_aw_valid"}, axi_req.aw_valid, 1'b0);
      check({tag, "_w_valid"},  axi_req.w_valid,  1'b0);
      check({tag, "_b_ready"},  axi_req.b_ready,  1'b0);
      check({tag, "_ar_valid"}, axi_req.ar_valid, 1'b0);
      check({tag, "_r_ready"},  axi_req.r_ready,  1'b0);
      check({tag, "_ready"},    reg_rsp.ready,    1'b0);
      check({tag, "_error"},    reg_rsp.error,    1'b0);
      check({tag, "_rdata"},    reg_rsp.rdata,    32'h0);
   endtask

   // Compare process: every cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (check_en) begin
         check("aw_valid", axi_req.aw_valid, exp_aw_valid);
         check("w_valid",  axi_req.w_valid,  exp_w_valid);
         check("b_ready",  axi_req.b_ready,  exp_b_ready);
         check("ar_valid", axi_req.ar_valid, exp_ar_valid);
         check("r_ready",  axi_req.r_ready,  exp_r_ready);
         check("reg_ready", reg_rsp.ready,   exp_ready);
         if (exp_aw_valid) begin
            check("aw_addr", axi_req.aw.addr, exp_addr);
            check("aw_prot", axi_req.aw.prot, 3'b000);
         end
         if (exp_w_valid) begin
            check("w_data", axi_req.w.data, exp_wdata);
            check("w_strb", axi_req.w.strb, exp_wstrb);
         end
         if (exp_ar_valid) begin
            check("ar_addr", axi_req.ar.addr, exp_addr);
            check("ar_prot", axi_req.ar.prot, 3'b000);
         end
         if (exp_ready) begin
            check("rsp_rdata", reg_rsp.rdata, exp_rdata);
            check("rsp_error", reg_rsp.error, exp_error);
         end
         if (axi_req.aw_valid && axi_rsp.aw_ready) aw_cnt++;
         if (axi_req.w_valid  && axi_rsp.w_ready)  w_cnt++;
         if (axi_req.b_ready  && axi_rsp.b_valid)  b_cnt++;
         if (axi_req.ar_valid && axi_rsp.ar_ready) ar_cnt++;
         if (axi_req.r_ready  && axi_rsp.r_valid)  r_cnt++;
         if (reg_rsp.ready) begin
            ready_cnt++;
            ready_rel = cur_rel;
            obs_error = reg_rsp.error;
            obs_rdata = reg_rsp.rdata;
         end
      end
   end

   // Runs one transaction. Cycle 0 is the cycle the request is captured.
   // Handshake cycles follow from the latency rules: address/data phase in
   // cycle 1 plus its wait, response channel opens the cycle after both
   // phases are done, regbus ready the cycle after the response beat (or
   // TMO cycles after the response channel opened on a timeout).
   task automatic applyStimulus(input bit wr, input logic [47:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int aw_wait, input int w_wait, input int ar_wait,
                                input int resp_wait, input logic [1:0] resp,
                                input logic [31:0] rdata, input int reset_at);
      int a_c, w_c, ar_c, s_c, hs_c, r_c, last;
      bit timed;
      a_c   = 1 + aw_wait;
      w_c   = 1 + w_wait;
      ar_c  = 1 + ar_wait;
      s_c   = wr ? ((a_c > w_c ? a_c : w_c) + 1) : (ar_c + 1);
      hs_c  = s_c + resp_wait;
      timed = TO_EN && (resp_wait >= TMO);
      r_c   = timed ? (s_c + TMO) : (hs_c + 1);
      last  = timed ? hs_c : (r_c + 1);
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      ready_cnt = 0; ready_rel = -1; obs_error = 1'bx; obs_rdata = 'x;
      for (int rel = 0; rel <= last; rel++) begin
         @(posedge clk);
         #1;
         cur_rel = rel;
         if (rel == reset_at) begin
            check_en = 1'b0;
            rst_n    = 1'b0;
            reg_req  = '0;
            axi_rsp  = '0;
            #1;
            checkResetOutputs("async_reset");
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            clearExpect();
            check_en = 1'b1;
            return;
         end
         // Initiator holds the request until it sees ready; after a timeout
         // it immediately issues a follow-on read that must wait for DRAIN.
         reg_req = '0;
         if (rel <= r_c) begin
            reg_req.valid = 1'b1;
            reg_req.addr  = addr;
            reg_req.write = wr;
            reg_req.wdata = wdata;
            reg_req.wstrb = wstrb;
         end else if (timed) begin
            reg_req.valid = 1'b1;
            reg_req.addr  = 48'h3000;
         end
         axi_rsp          = '0;
         axi_rsp.aw_ready = wr && (rel == a_c);
         axi_rsp.w_ready  = wr && (rel == w_c);
         axi_rsp.ar_ready = !wr && (rel == ar_c);
         axi_rsp.b_valid  = wr && (rel == hs_c);
         axi_rsp.b.resp   = resp;
         axi_rsp.r_valid  = !wr && (rel == hs_c);
         axi_rsp.r.data   = rdata;
         axi_rsp.r.resp   = resp;
         exp_aw_valid = wr && (rel >= 1) && (rel <= a_c);
         exp_w_valid  = wr && (rel >= 1) && (rel <= w_c);
         exp_ar_valid = !wr && (rel >= 1) && (rel <= ar_c);
         exp_b_ready  = wr && (rel >= s_c) && (rel <= hs_c);
         exp_r_ready  = !wr && (rel >= s_c) && (rel <= hs_c);
         exp_ready    = (rel == r_c);
         exp_addr     = addr;
         exp_wdata    = wdata;
         exp_wstrb    = wstrb;
         exp_rdata    = (wr || timed) ? 32'h0 : rdata;
         exp_error    = timed ? 1'b1 : (resp != 2'b00);
      end
   endtask

   // Hand-computed per-transaction totals.
   task automatic checkOutput(input string tag, input int rdy_cycle, input logic err,
                              input logic [31:0] rd, input int n_aw, input int n_w,
                              input int n_b, input int n_ar, input int n_r);
      check({tag, "_ready_cycle"}, ready_rel, rdy_cycle);
      check({tag, "_ready_count"}, ready_cnt, 1);
      check({tag, "_error"},       obs_error, err);
      check({tag, "_rdata"},       obs_rdata, rd);
      check({tag, "_aw_count"},    aw_cnt, n_aw);
      check({tag, "_w_count"},     w_cnt,  n_w);
      check({tag, "_b_count"},     b_cnt,  n_b);
      check({tag, "_ar_count"},    ar_cnt, n_ar);
      check({tag, "_r_count"},     r_cnt,  n_r);
   endtask

   initial begin
      rst_n   = 1'b0;
      reg_req = '0;
      axi_rsp = '0;
      clearExpect();
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst_n    = 1'b1;
      check_en = 1'b1;

      $display("[TB] write 0x1000, always-ready slave");
      applyStimulus(1'b1, 48'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, -1);
      checkOutput("wr_basic", 3, 1'b0, 32'h0, 1, 1, 1, 0, 0);

      $display("[TB] read 0x2004, five R wait cycles");
      applyStimulus(1'b0, 48'h2004, 32'h0, 4'h0, 0, 0, 0, 5, 2'b00, 32'h12345678, -1);
      checkOutput("rd_wait", 8, 1'b0, 32'h12345678, 0, 0, 0, 1, 1);

      $display("[TB] write, AW ready three cycles before W");
      applyStimulus(1'b1, 48'h1010, 32'hA5A5_0001, 4'h3, 0, 3, 0, 0, 2'b00, 32'h0, -1);
      checkOutput("wr_aw_first", 6, 1'b0, 32'h0, 1, 1, 1, 0, 0);

      $display("[TB] write, W ready three cycles before AW");
      applyStimulus(1'b1, 48'h1020, 32'h5A5A_0002, 4'hC, 3, 0, 0, 0, 2'b00, 32'h0, -1);
      checkOutput("wr_w_first", 6, 1'b0, 32'h0, 1, 1, 1, 0, 0);

      $display("[TB] read returning SLVERR");
      applyStimulus(1'b0, 48'h2008, 32'h0, 4'h0, 0, 0, 2, 1, 2'b10, 32'hCAFEF00D, -1);
      checkOutput("rd_slverr", 6, 1'b1, 32'hCAFEF00D, 0, 0, 0, 1, 1);

      $display("[TB] write returning DECERR");
      applyStimulus(1'b1, 48'h1030, 32'h0000_1234, 4'h1, 0, 0, 0, 2, 2'b11, 32'h0, -1);
      checkOutput("wr_decerr", 5, 1'b1, 32'h0, 1, 1, 1, 0, 0);

      $display("[TB] reset asserted in WAIT_R");
      applyStimulus(1'b0, 48'h2010, 32'h0, 4'h0, 0, 0, 0, 50, 2'b00, 32'h11112222, 5);
      applyStimulus(1'b0, 48'h0040, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h0BADC0DE, -1);
      checkOutput("rd_after_reset", 3, 1'b0, 32'h0BADC0DE, 0, 0, 0, 1, 1);

`ifdef REG_TO_AXI_LITE_TIMEOUT_EN
      $display("[TB] watchdog: B arrives 100 cycles after timeout");
      applyStimulus(1'b1, 48'h1040, 32'h0F0F0F0F, 4'hF, 0, 0, 0, TMO + 100, 2'b00, 32'h0, -1);
      checkOutput("wr_timeout", 18, 1'b1, 32'h0, 1, 1, 1, 0, 0);
      applyStimulus(1'b0, 48'h3000, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h55AA55AA, -1);
      checkOutput("rd_after_drain", 3, 1'b0, 32'h55AA55AA, 0, 0, 0, 1, 1);
`endif

      @(posedge clk);
      #1;
      reg_req = '0;
      axi_rsp = '0;
      clearExpect();
      repeat (2) @(posedge clk);
      check_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
